// File: rtl/pci_pkg.sv
// Shared constants and types for the PCI initiator: bus commands, byte-enable
// codes and the bus-cycle state encoding.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] CMD_MEM_WRITE = 4'h7;
    localparam logic [3:0] BE_ALL        = 4'h0;
    localparam logic [3:0] BE_IDLE       = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ABORT
    } state_t;

    function automatic logic [3:0] cmd_for(input logic is_write);
        return is_write ? CMD_MEM_WRITE : CMD_MEM_READ;
    endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Request port and PCI control signals of the initiator; AD stays a plain
// inout on the top because it is a resolved tri-state net.
interface pci_initiator_if #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [31:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic [31:0]      wr_data;
    logic             wr_ack;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             done;
    logic             abort;
    logic             FRAME_;
    logic             IRDY_;
    logic [3:0]       C_BE_;
    logic             TRDY_;
    logic             DEVSEL_;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wr_data, TRDY_, DEVSEL_,
        output req_ready, wr_ack, rd_data, rd_valid, done, abort, FRAME_, IRDY_, C_BE_
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wr_data, TRDY_, DEVSEL_,
        input  req_ready, wr_ack, rd_data, rd_valid, done, abort, FRAME_, IRDY_, C_BE_
    );

endinterface

// File: rtl/pci_devsel_timer.sv
// Counts data-phase clocks without DEVSEL_ and flags the edge on which the
// initiator must give up; once DEVSEL_ has been seen low the count freezes.
module pci_devsel_timer #(
    parameter int DEVSEL_TIMEOUT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_devsel_n,
    output logic o_expired
);
    localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_seen;

    // High during the cycle whose closing edge is the timeout-th edge without DEVSEL_.
    assign o_expired = i_enable && i_devsel_n && !r_seen &&
                       (r_count == CNT_W'(DEVSEL_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_seen  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_seen  <= 1'b0;
        end else if (i_enable) begin
            if (!i_devsel_n) begin
                r_seen <= 1'b1;
            end else if (!r_seen && (r_count != CNT_W'(DEVSEL_TIMEOUT))) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: turns single/burst memory read and write requests into
// FRAME_/IRDY_ bus cycles, with master abort when no target claims the cycle.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int MAX_BURST      = 16,
    parameter int LEN_W          = $clog2(MAX_BURST + 1),
    parameter int DEVSEL_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            reset,
    pci_initiator_if.master bus,
    inout  wire [31:0]      AD
);

    state_t           r_state, w_state_next;
    logic [LEN_W-1:0] r_remaining, w_remaining_next;
    logic [31:0]      r_addr, w_addr_next;
    logic [3:0]       r_cmd, w_cmd_next;
    logic             r_write, w_write_next;

    logic             r_frame_n, w_frame_n_next;
    logic             r_irdy_n, w_irdy_n_next;
    logic [3:0]       r_cbe, w_cbe_next;
    logic             r_ad_oe, w_ad_oe_next;
    logic             r_ad_wr, w_ad_wr_next;
    logic             r_req_ready, w_req_ready_next;
    logic [31:0]      r_rd_data, w_rd_data_next;
    logic             r_rd_valid, w_rd_valid_next;
    logic             r_wr_ack, w_wr_ack_next;
    logic             r_done, w_done_next;
    logic             r_abort, w_abort_next;

    logic             w_timer_clear;
    logic             w_timer_en;
    logic             w_expired;
    logic             w_xfer;
    logic [LEN_W-1:0] w_len_clamped;

    pci_devsel_timer #(
        .DEVSEL_TIMEOUT(DEVSEL_TIMEOUT)
    ) u_devsel_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .i_devsel_n(bus.DEVSEL_),
        .o_expired (w_expired)
    );

    assign w_len_clamped = (bus.req_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.req_len;
    assign w_xfer        = (r_state == DATA) && !r_irdy_n && !bus.TRDY_ && !bus.DEVSEL_;

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_addr_next      = r_addr;
        w_cmd_next       = r_cmd;
        w_write_next     = r_write;
        w_rd_data_next   = r_rd_data;
        w_rd_valid_next  = 1'b0;
        w_wr_ack_next    = 1'b0;
        w_done_next      = 1'b0;
        w_abort_next     = 1'b0;
        w_timer_clear    = 1'b0;
        w_timer_en       = 1'b0;
        w_frame_n_next   = 1'b1;
        w_irdy_n_next    = 1'b1;
        w_cbe_next       = BE_IDLE;
        w_ad_oe_next     = 1'b0;
        w_ad_wr_next     = 1'b0;
        w_req_ready_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    if (w_len_clamped == '0) begin
                        w_abort_next = 1'b1;
                    end else begin
                        w_addr_next      = bus.req_addr;
                        w_cmd_next       = cmd_for(bus.req_write);
                        w_write_next     = bus.req_write;
                        w_remaining_next = w_len_clamped;
                        w_state_next     = ADDR;
                    end
                end
            end
            ADDR: begin
                w_timer_clear = 1'b1;
                w_state_next  = DATA;
            end
            DATA: begin
                w_timer_en = 1'b1;
                // A completing transfer wins over a timeout landing on the same edge.
                if (w_xfer) begin
                    if (r_write) begin
                        w_wr_ack_next = 1'b1;
                    end else begin
                        w_rd_data_next  = AD;
                        w_rd_valid_next = 1'b1;
                    end
                    if (r_remaining == LEN_W'(1)) begin
                        w_remaining_next = '0;
                        w_done_next      = 1'b1;
                        w_state_next     = IDLE;
                    end else begin
                        w_remaining_next = r_remaining - LEN_W'(1);
                    end
                end else if (w_expired) begin
                    w_state_next = ABORT;
                end
            end
            ABORT: begin
                w_abort_next = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Bus outputs are registered from the state being entered.
        case (w_state_next)
            IDLE: begin
                w_req_ready_next = 1'b1;
            end
            ADDR: begin
                w_frame_n_next = 1'b0;
                w_cbe_next     = w_cmd_next;
                w_ad_oe_next   = 1'b1;
            end
            DATA: begin
                w_frame_n_next = (w_remaining_next == LEN_W'(1));
                w_irdy_n_next  = 1'b0;
                w_cbe_next     = BE_ALL;
                w_ad_oe_next   = w_write_next;
                w_ad_wr_next   = 1'b1;
            end
            ABORT: begin
                w_irdy_n_next = 1'b0;
            end
            default: begin
                w_req_ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_addr      <= '0;
            r_cmd       <= BE_IDLE;
            r_write     <= 1'b0;
            r_frame_n   <= 1'b1;
            r_irdy_n    <= 1'b1;
            r_cbe       <= BE_IDLE;
            r_ad_oe     <= 1'b0;
            r_ad_wr     <= 1'b0;
            r_req_ready <= 1'b1;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_addr      <= w_addr_next;
            r_cmd       <= w_cmd_next;
            r_write     <= w_write_next;
            r_frame_n   <= w_frame_n_next;
            r_irdy_n    <= w_irdy_n_next;
            r_cbe       <= w_cbe_next;
            r_ad_oe     <= w_ad_oe_next;
            r_ad_wr     <= w_ad_wr_next;
            r_req_ready <= w_req_ready_next;
            r_rd_data   <= w_rd_data_next;
            r_rd_valid  <= w_rd_valid_next;
            r_wr_ack    <= w_wr_ack_next;
            r_done      <= w_done_next;
            r_abort     <= w_abort_next;
        end
    end

    // Write data flows straight from wr_data so the next word is already on
    // the bus in the cycle its predecessor's wr_ack is seen.
    assign AD = r_ad_oe ? (r_ad_wr ? bus.wr_data : r_addr) : 32'hzzzz_zzzz;

    assign bus.FRAME_    = r_frame_n;
    assign bus.IRDY_     = r_irdy_n;
    assign bus.C_BE_     = r_cbe;
    assign bus.req_ready = r_req_ready;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.wr_ack    = r_wr_ack;
    assign bus.done      = r_done;
    assign bus.abort     = r_abort;

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: a behavioural PCI target plus an event scoreboard
// for rd_valid/wr_ack/done/abort and per-transaction bus-phase counts.
module tb_pci_initiator;
    import pci_pkg::*;

    localparam int          EV_RD    = 1;
    localparam int          EV_WR    = 2;
    localparam int          EV_DONE  = 3;
    localparam int          EV_ABORT = 4;
    localparam logic [31:0] PROBE    = 32'h5A5A_A5A5;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    logic        clk;
    logic        reset;
    wire  [31:0] AD;
    logic        tgt_oe;
    logic        tgt_probe;
    logic [31:0] tgt_data;
    int          tgt_mode;
    int          n_vec;
    int          n_miss;
    int          n_rd_seen;
    ev_t         sb[$];

    pci_initiator_if #(.MAX_BURST(16)) bus ();

    pci_initiator #(
        .MAX_BURST     (16),
        .DEVSEL_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .AD   (AD)
    );

    assign AD = tgt_probe ? PROBE : (tgt_oe ? tgt_data : 32'hzzzz_zzzz);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tgt_word(input int idx);
        case (idx)
            0:       return 32'hCAFE_CAFE;
            1:       return 32'hFACE_FACE;
            2:       return 32'hCAFE_FACE;
            default: return {16'hBE00, 16'(idx)};
        endcase
    endfunction

    // Target: mode 0 never claims, 1 zero-wait, 2 one wait state after the
    // first word, 3 claims only on the 4th data cycle (timeout boundary).
    initial begin : target
        int          t_idx;
        int          t_dcyc;
        logic        t_waited;
        logic        t_prev_irdy_n;
        logic [3:0]  t_cmd;
        t_idx = 0; t_dcyc = 0; t_waited = 1'b0; t_prev_irdy_n = 1'b1; t_cmd = 4'h0;
        tgt_oe = 1'b0; tgt_data = '0;
        bus.TRDY_ = 1'b1; bus.DEVSEL_ = 1'b1;
        forever begin
            @(negedge clk);
            if (!t_prev_irdy_n && !bus.TRDY_ && !bus.DEVSEL_) t_idx++;
            t_prev_irdy_n = bus.IRDY_;
            bus.TRDY_ = 1'b1; bus.DEVSEL_ = 1'b1; tgt_oe = 1'b0;
            if (!bus.FRAME_ && bus.IRDY_) begin
                t_idx = 0; t_dcyc = 0; t_waited = 1'b0; t_cmd = bus.C_BE_;
            end else if (!bus.IRDY_ && tgt_mode != 0) begin
                if (!(tgt_mode == 3 && t_dcyc < 3)) begin
                    bus.DEVSEL_ = 1'b0;
                    if (tgt_mode == 2 && t_idx == 1 && !t_waited) t_waited = 1'b1;
                    else bus.TRDY_ = 1'b0;
                    if (t_cmd == CMD_MEM_READ) begin
                        tgt_oe = 1'b1;
                        tgt_data = tgt_word(t_idx);
                    end
                end
                t_dcyc++;
            end
        end
    end

    task automatic sb_check(input int kind, input logic [31:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event", 32'(kind), 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_RD) chk("sb_rd_data", data, e.data);
        end
    endtask

    initial begin : monitor
        n_rd_seen = 0;
        forever begin
            @(negedge clk);
            if (bus.rd_valid) begin
                n_rd_seen++;
                sb_check(EV_RD, bus.rd_data);
            end
            if (bus.wr_ack) sb_check(EV_WR, 32'd0);
            if (bus.done)   sb_check(EV_DONE, 32'd0);
            if (bus.abort)  sb_check(EV_ABORT, 32'd0);
        end
    end

    task automatic push_ev(input int kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input int len);
        int guard;
        int n;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        n = (len > 16) ? 16 : len;
        if (n == 0 || tgt_mode == 0) begin
            push_ev(EV_ABORT, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (wr) push_ev(EV_WR, 32'd0);
                else    push_ev(EV_RD, tgt_word(i));
            end
            push_ev(EV_DONE, 32'd0);
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = 5'(len);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr, input int len,
                           input logic [31:0] wbase, input int exp_mid, input int exp_last,
                           input int exp_addr);
        int cyc;
        int widx;
        int n_mid;
        int n_last;
        int n_addr;
        n_mid = 0; n_last = 0; n_addr = 0; widx = 0; cyc = 0;
        bus.wr_data = wbase;
        issue(wr, addr, len);
        while ((sb.size() != 0 || !bus.req_ready) && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.wr_ack) begin
                widx++;
                bus.wr_data = wbase + 32'(widx);
            end
            #1;
            if (!bus.FRAME_ && bus.IRDY_) begin
                n_addr++;
                chk({tag, "_addr_ad"}, AD, addr);
                chk({tag, "_addr_cmd"}, 32'(bus.C_BE_), wr ? 32'h7 : 32'h6);
            end
            if (!bus.IRDY_) begin
                if (bus.FRAME_) n_last++;
                else            n_mid++;
            end
            if (!bus.IRDY_ && wr && !bus.TRDY_ && !bus.DEVSEL_) begin
                chk({tag, "_wr_ad"}, AD, wbase + 32'(widx));
                chk({tag, "_wr_be"}, 32'(bus.C_BE_), 32'h0);
            end
        end
        if (cyc >= 200) chk({tag, "_timeout"}, 32'(cyc), 32'd0);
        chk({tag, "_frame_low_phases"}, 32'(n_mid), 32'(exp_mid));
        chk({tag, "_frame_high_irdy_low"}, 32'(n_last), 32'(exp_last));
        chk({tag, "_addr_phases"}, 32'(n_addr), 32'(exp_addr));
        chk({tag, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
        $display("txn %s: wr=%0d addr=%h len=%0d mid=%0d last=%0d addr_ph=%0d cycles=%0d",
                 tag, wr, addr, len, n_mid, n_last, n_addr, cyc);
    endtask

    initial begin : main
        int cyc;
        int rd0;
        n_vec = 0; n_miss = 0;
        tgt_mode = 1; tgt_probe = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wr_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_frame", 32'(bus.FRAME_), 32'd1);
        chk("rst_irdy", 32'(bus.IRDY_), 32'd1);
        chk("rst_cbe", 32'(bus.C_BE_), 32'hF);
        chk("rst_ad_released", AD, PROBE);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_pulses", {28'd0, bus.rd_valid, bus.wr_ack, bus.done, bus.abort}, 32'd0);
        @(negedge clk);
        reset = 1'b0; tgt_probe = 1'b0;
        repeat (2) @(negedge clk);

        tgt_mode = 2;
        run_txn("rd_burst3", 1'b0, 32'h0000_1000, 3, 32'd0, 3, 1, 1);
        tgt_mode = 1;
        run_txn("wr_single", 1'b1, 32'h0000_2000, 1, 32'hDEAD_BEEF, 0, 1, 1);
        tgt_mode = 2;
        run_txn("wr_burst3", 1'b1, 32'h0000_2100, 3, 32'h1111_0000, 3, 1, 1);
        tgt_mode = 0;
        run_txn("no_target", 1'b0, 32'h0000_3000, 2, 32'd0, 4, 1, 1);
        tgt_mode = 3;
        run_txn("late_devsel", 1'b0, 32'h0000_3100, 1, 32'd0, 0, 4, 1);
        tgt_mode = 1;
        run_txn("len_zero", 1'b0, 32'h0000_3200, 0, 32'd0, 0, 0, 0);
        run_txn("len_20", 1'b0, 32'h0000_3300, 20, 32'd0, 15, 1, 1);

        // Reset in the middle of a 4-word read, after two words.
        tgt_mode = 1;
        issue(1'b0, 32'h0000_5000, 4);
        rd0 = n_rd_seen; cyc = 0;
        while ((n_rd_seen - rd0) < 2 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 50) chk("midrst_wait", 32'(n_rd_seen - rd0), 32'd2);
        chk("midrst_in_burst", 32'(bus.FRAME_), 32'd0);
        tgt_probe = 1'b1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midrst_frame", 32'(bus.FRAME_), 32'd1);
        chk("midrst_irdy", 32'(bus.IRDY_), 32'd1);
        chk("midrst_cbe", 32'(bus.C_BE_), 32'hF);
        chk("midrst_ad_released", AD, PROBE);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        $display("txn midrst: reset after %0d read words", n_rd_seen - rd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; tgt_probe = 1'b0;
        repeat (3) @(negedge clk);
        run_txn("post_rst", 1'b0, 32'h0000_6000, 1, 32'd0, 0, 1, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
Synthesizable PCI bus initiator (master). It sits directly upstream of the PCI target on the shared bus and drives FRAME_, IRDY_, C_BE_ and the address/write data on AD. It consumes DEVSEL_, TRDY_ and read data from the target. A simple request port lets the testbench or a DMA engine launch single or burst memory reads/writes, with master-abort on DEVSEL_ timeout.

Parameters:
MAX_BURST, 16, maximum data phases per transaction.
LEN_W, $clog2(MAX_BURST+1), width of req_len.
DEVSEL_TIMEOUT, 4, cycles after the address phase without DEVSEL_ low before master abort.

Ports:
clk  input  1  bus clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request strobe.
req_ready  output  1  high only in IDLE; request accepted when req_valid&&req_ready.
req_write  input  1  1 = memory write (C_BE_ 4'h7), 0 = memory read (4'h6).
req_addr  input  32  start address driven in the address phase.
req_len  input  LEN_W  number of data phases; 0 is illegal; values above MAX_BURST are clamped to MAX_BURST.
wr_data  input  32  current write word; must be held stable until wr_ack.
wr_ack  output  1  1-cycle pulse per completed write data phase.
rd_data  output  32  captured read word.
rd_valid  output  1  1-cycle pulse per completed read data phase.
done  output  1  1-cycle pulse on normal completion.
abort  output  1  1-cycle pulse on master abort or illegal length.
FRAME_  output  1  PCI FRAME#, active low.
IRDY_  output  1  PCI IRDY#, active low.
C_BE_  output  4  command in the address phase; byte enables 4'h0 in data phases; 4'hF when idle.
TRDY_  input  1  PCI TRDY#.
DEVSEL_  input  1  PCI DEVSEL#.
AD  inout  32  tri-stated through an internal enable; driven only in ADDR, and in DATA for writes.

Behaviour:
- Reset (async, immediate, including mid-transaction): FRAME_=1, IRDY_=1, C_BE_=4'hF, AD released, req_ready=1, rd_data=0, and rd_valid/wr_ack/done/abort all 0. State goes to IDLE and the remaining-phase counter is cleared.
- All outputs are registered. Bus inputs are sampled on posedge clk only.
- IDLE: on accept, latch addr, cmd and len (clamped); next state is ADDR.
  - If len==0, do not touch the bus; pulse abort on the next cycle and stay in IDLE.
- ADDR (exactly 1 cycle): FRAME_=0, IRDY_=1, AD=addr, C_BE_=cmd. Clear the DEVSEL_ timer; next state is DATA.
- DATA:
  - IRDY_=0 and C_BE_=4'h0. FRAME_=0 while remaining>1 and FRAME_=1 while remaining==1 (final phase).
  - Write: AD=wr_data. Read: AD released; turnaround is implicit in the first read data phase.
  - A transfer completes at a posedge where IRDY_==0 && TRDY_==0 && DEVSEL_==0.
    - Read: rd_data<=AD and rd_valid pulses.
    - Write: wr_ack pulses.
    - remaining decrements.
  - TRDY_ high with DEVSEL_ low is a wait state: hold all outputs and do not decrement.
  - Completion of the last transfer leads to IDLE: FRAME_=1, IRDY_=1, AD released, done pulses the same cycle. Back-to-back requests therefore see one idle cycle.
- DEVSEL_ timer: counts posedges in DATA while DEVSEL_==1, and is frozen once DEVSEL_ has been seen low.
  - On reaching DEVSEL_TIMEOUT, go to ABORT.
- ABORT (1 cycle): FRAME_=1, IRDY_=0, AD released. Then go to IDLE with IRDY_=1 and abort pulsed. No rd_valid or wr_ack is produced.
- A target that sets DEVSEL_ low with TRDY_ low on the same edge as the timer expiry completes the transfer; transfer takes priority over abort.
- FRAME_ never reasserts within a transaction. IRDY_ never deasserts before the final transfer except in ABORT.

Decomposition:
- Package pci_pkg holds:
  - CMD_MEM_READ=4'h6 and CMD_MEM_WRITE=4'h7;
  - BE_ALL=4'h0 and BE_IDLE=4'hF;
  - state enum {IDLE, ADDR, DATA, ABORT}.
- One natural sub-module: pci_devsel_timer (clear, enable, sample DEVSEL_, expired output, parameter DEVSEL_TIMEOUT).

Test Plan:
- Read burst, addr 32'h0000_1000, len=3, against the team target model (one wait state after the first word):
  - rd_valid pulses 3 times with CAFE_CAFE, FACE_FACE, CAFE_FACE;
  - FRAME_ high during the third data phase only; done pulses once; abort stays 0.
- Single write, addr 32'h0000_2000, wr_data=32'hDEAD_BEEF, target TRDY_/DEVSEL_ low on the first DATA cycle:
  - AD=DEADBEEF, C_BE_=4'h0, FRAME_=1 and IRDY_=0 for one cycle;
  - wr_ack and done each pulse once.
- No target (DEVSEL_ held 1), read len=2:
  - after 4 DATA cycles, one ABORT cycle with FRAME_=1 and IRDY_=0;
  - abort pulses; rd_valid stays 0; req_ready returns to 1.
- reset asserted in the middle of a len=4 read, after 2 transfers:
  - FRAME_/IRDY_ go to 1 and AD is released immediately;
  - done and abort are never pulsed; a new request is accepted after reset.
- Illegal and oversized length:
  - req_len=0 gives FRAME_ held 1 and abort pulsed once;
  - req_len=20 gives exactly 16 data phases.
